// File: rtl/obi_data_mem_responder_if.sv
// OBI data-port bundle between the LSU (master) and the data memory responder (slave).
interface obi_data_mem_responder_if;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        gnt_stall_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, gnt_stall_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, gnt_stall_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
endinterface

// File: rtl/obi_data_mem_responder.sv
// OBI data-side memory responder: grants requests, applies byte-enabled writes to a
// word-organised RAM and returns every transaction in order after a fixed latency.
module obi_data_mem_responder #(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter int unsigned RVALID_LATENCY  = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] BASE_ADDR       = 32'h0
) (
    input logic                     clk,
    input logic                     rst,
    obi_data_mem_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic [31:0]   mem [DEPTH_WORDS];
    resp_t         pipe [RVALID_LATENCY];
    logic [CW-1:0] outstanding;

    logic [31:0]   offset;
    logic [29:0]   word;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          accept;
    logic          rvalid;
    resp_t         resp_in;

    // Address decode relative to the memory base.
    assign offset   = bus.data_addr_i - BASE_ADDR;
    assign word     = offset[31:2];
    assign in_range = {2'b00, word} < 32'(DEPTH_WORDS);
    assign idx      = word[AW-1:0];

    assign rvalid = pipe[RVALID_LATENCY-1].valid;

    // A response leaving the pipe this cycle frees a slot, so grant may stay high at the limit.
    assign bus.data_gnt_o = bus.data_req_i && !bus.gnt_stall_i
                            && ((outstanding < CW'(MAX_OUTSTANDING)) || rvalid);
    assign accept = bus.data_req_i && bus.data_gnt_o;

    always_comb begin
        resp_in       = '0;
        resp_in.valid = accept;
        resp_in.err   = accept && !in_range;
        if (accept && in_range && !bus.data_we_i) begin
            resp_in.rdata = mem[idx];
        end
    end

    assign bus.data_rvalid_o = rvalid;
    assign bus.data_rdata_o  = pipe[RVALID_LATENCY-1].rdata;
    assign bus.data_err_o    = pipe[RVALID_LATENCY-1].err;

    // Fixed-latency response shift pipe; reset drops anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RVALID_LATENCY); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= resp_in;
            for (int i = 1; i < int'(RVALID_LATENCY); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else if (accept && !rvalid) begin
            outstanding <= outstanding + CW'(1);
        end else if (!accept && rvalid) begin
            outstanding <= outstanding - CW'(1);
        end
    end

    // RAM contents survive reset; only enabled lanes are written.
    always_ff @(posedge clk) begin
        if (accept && bus.data_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_be_i[b]) begin
                    mem[idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_obi_data_mem_responder.sv
// Scoreboard bench for obi_data_mem_responder: instance 0 runs latency 1, instance 1 latency 2.
module tb_obi_data_mem_responder;
    localparam int unsigned DEPTH = 1024;
    localparam int          MAXO  = 2;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req   [2];
    logic [31:0] addr  [2];
    logic        we    [2];
    logic [3:0]  be    [2];
    logic [31:0] wdata [2];
    logic        stall [2];
    logic        gnt   [2];
    logic        rvalid[2];
    logic [31:0] rdata [2];
    logic        err   [2];

    obi_data_mem_responder_if b0 ();
    obi_data_mem_responder_if b1 ();

    assign b0.data_req_i   = req[0];
    assign b0.data_addr_i  = addr[0];
    assign b0.data_we_i    = we[0];
    assign b0.data_be_i    = be[0];
    assign b0.data_wdata_i = wdata[0];
    assign b0.gnt_stall_i  = stall[0];
    assign gnt[0]    = b0.data_gnt_o;
    assign rvalid[0] = b0.data_rvalid_o;
    assign rdata[0]  = b0.data_rdata_o;
    assign err[0]    = b0.data_err_o;

    assign b1.data_req_i   = req[1];
    assign b1.data_addr_i  = addr[1];
    assign b1.data_we_i    = we[1];
    assign b1.data_be_i    = be[1];
    assign b1.data_wdata_i = wdata[1];
    assign b1.gnt_stall_i  = stall[1];
    assign gnt[1]    = b1.data_gnt_o;
    assign rvalid[1] = b1.data_rvalid_o;
    assign rdata[1]  = b1.data_rdata_o;
    assign err[1]    = b1.data_err_o;

    obi_data_mem_responder #(
        .DEPTH_WORDS(DEPTH), .RVALID_LATENCY(1), .MAX_OUTSTANDING(MAXO), .BASE_ADDR(32'h0)
    ) u_dut0 (.clk(clk), .rst(rst), .bus(b0));

    obi_data_mem_responder #(
        .DEPTH_WORDS(DEPTH), .RVALID_LATENCY(2), .MAX_OUTSTANDING(MAXO), .BASE_ADDR(32'h0)
    ) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mdl [2][DEPTH];
    exp_t        q0[$];
    exp_t        q1[$];
    int          out [2];
    int          max_out [2];
    int          rv_count [2];
    time         last_rv_t [2];
    time         rv_t1[$];
    logic [31:0] last_rd [2];
    logic        last_err [2];
    logic        prev_wait [2];
    logic [31:0] prev_addr [2];
    logic [31:0] prev_wdata [2];
    logic        prev_we [2];
    logic [3:0]  prev_be [2];

    // Reference memory: update on accept and queue the response the DUT owes.
    function automatic void predict(input int d, input logic w, input logic [31:0] a,
                                    input logic [3:0] b, input logic [31:0] wd);
        exp_t e;
        int   ix;
        ix = int'(a[11:2]);
        if (a[31:2] >= 30'(DEPTH)) begin
            e = {32'h0, 1'b1};
        end else if (w) begin
            for (int k = 0; k < 4; k++) begin
                if (b[k]) mdl[d][ix][8*k +: 8] = wd[8*k +: 8];
            end
            e = {32'h0, 1'b0};
        end else begin
            e = {mdl[d][ix], 1'b0};
        end
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Per-cycle monitor: grant rule, scoreboard pop, outstanding bounds, request stability.
    always @(negedge clk) begin
        exp_t e;
        logic exp_g;
        logic acc;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                if (d == 0) q0.delete();
                else        q1.delete();
                out[d]       = 0;
                prev_wait[d] = 1'b0;
            end else begin
                exp_g = req[d] && !stall[d] && ((out[d] < MAXO) || rvalid[d]);
                checks++;
                if (gnt[d] !== exp_g)
                    $display("FAIL gnt d%0d t=%0t: got %b want %b", d, $time, gnt[d], exp_g);
                if (gnt[d] !== exp_g) failures++;
                if (prev_wait[d] && req[d]) begin
                    checks++;
                    if (addr[d] !== prev_addr[d] || we[d] !== prev_we[d] ||
                        be[d] !== prev_be[d] || wdata[d] !== prev_wdata[d]) begin
                        failures++;
                        $display("FAIL req_stable d%0d t=%0t: addr %h want %h", d, $time, addr[d], prev_addr[d]);
                    end
                end
                if (rvalid[d]) begin
                    rv_count[d]++;
                    last_rv_t[d] = $time;
                    if (d == 1) rv_t1.push_back($time);
                    checks++;
                    if (qsize(d) == 0 || out[d] == 0) begin
                        failures++;
                        $display("FAIL spurious_rvalid d%0d t=%0t: got rvalid=1 want 0", d, $time);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        last_rd[d]  = rdata[d];
                        last_err[d] = err[d];
                        if (rdata[d] !== e.rdata) begin
                            failures++;
                            $display("FAIL rdata d%0d t=%0t: got %h want %h", d, $time, rdata[d], e.rdata);
                        end
                        checks++;
                        if (err[d] !== e.err) begin
                            failures++;
                            $display("FAIL err d%0d t=%0t: got %b want %b", d, $time, err[d], e.err);
                        end
                    end
                end
                acc = req[d] && gnt[d];
                if (acc) predict(d, we[d], addr[d], be[d], wdata[d]);
                out[d] = out[d] + int'(acc) - ((rvalid[d] && out[d] > 0) ? 1 : 0);
                if (out[d] > max_out[d]) max_out[d] = out[d];
                checks++;
                if (out[d] > MAXO) begin
                    failures++;
                    $display("FAIL outstanding d%0d t=%0t: got %0d want <= %0d", d, $time, out[d], MAXO);
                end
                prev_wait[d]  = req[d] && !gnt[d];
                prev_addr[d]  = addr[d];
                prev_we[d]    = we[d];
                prev_be[d]    = be[d];
                prev_wdata[d] = wdata[d];
            end
        end
    end

    task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] wd, output int waited, output time gt);
        req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        waited = 0;
        gt = 0;
        forever begin
            @(negedge clk);
            if (gnt[d]) begin
                gt = $time;
                break;
            end
            waited++;
            if (waited > 50) begin
                checks++;
                failures++;
                $display("FAIL grant_timeout d%0d: got no grant in %0d cycles want grant", d, waited);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int d);
        req[d] = 1'b0;
    endtask

    task automatic wait_drain(input int d);
        repeat (20) begin
            if (qsize(d) == 0) break;
            @(negedge clk); #1;
        end
        checks++;
        if (qsize(d) != 0) begin
            failures++;
            $display("FAIL drain d%0d: got %0d pending want 0", d, qsize(d));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; be[d] = '0; wdata[d] = '0; stall[d] = 1'b0;
            out[d] = 0; max_out[d] = 0; rv_count[d] = 0; prev_wait[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rvalid[d] !== 1'b0 || rdata[d] !== 32'h0 || err[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs d%0d: got rv=%b rd=%h err=%b want 0/0/0", d, rvalid[d], rdata[d], err[d]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rvalid[d] !== 1'b0 || gnt[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL idle d%0d: got rv=%b gnt=%b want 0/0", d, rvalid[d], gnt[d]);
                end
            end
            checks++;
            if (u_dut0.outstanding !== '0 || u_dut1.outstanding !== '0) begin
                failures++;
                $display("FAIL idle_outstanding: got %0d/%0d want 0/0", u_dut0.outstanding, u_dut1.outstanding);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int w; time gt;
        issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, w, gt); idle(0); wait_drain(0);
        checks++;
        if ((last_rv_t[0] - gt) !== 64'd10) begin
            failures++;
            $display("FAIL write_latency: got %0t want 10", last_rv_t[0] - gt);
        end
        checks++;
        if (last_rd[0] !== 32'h0 || last_err[0] !== 1'b0) begin
            failures++;
            $display("FAIL write_resp: got rd=%h err=%b want 0/0", last_rd[0], last_err[0]);
        end
        issue(0, 1'b0, 32'h10, 4'h0, 32'h0, w, gt); idle(0); wait_drain(0);
        checks++;
        if (last_rd[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL read_full: got %h want deadbeef", last_rd[0]);
        end
    endtask

    task automatic test_partial_write();
        int w; time gt;
        issue(0, 1'b1, 32'h10, 4'b0001, 32'h000000AA, w, gt);
        issue(0, 1'b0, 32'h10, 4'hF, 32'h0, w, gt); idle(0); wait_drain(0);
        checks++;
        if (last_rd[0] !== 32'hDEADBEAA) begin
            failures++;
            $display("FAIL partial_lane0: got %h want deadbeaa", last_rd[0]);
        end
        issue(0, 1'b1, 32'h10, 4'b1100, 32'h12340000, w, gt);
        issue(0, 1'b0, 32'h10, 4'b0001, 32'h0, w, gt); idle(0); wait_drain(0);
        checks++;
        if (last_rd[0] !== 32'h1234BEAA) begin
            failures++;
            $display("FAIL partial_upper: got %h want 1234beaa", last_rd[0]);
        end
    endtask

    task automatic test_back_to_back();
        int w0, w1, w2; time gt0, gt;
        issue(1, 1'b1, 32'h0, 4'hF, 32'h11111111, w0, gt);
        issue(1, 1'b1, 32'h4, 4'hF, 32'h22222222, w0, gt);
        issue(1, 1'b1, 32'h8, 4'hF, 32'h33333333, w0, gt);
        idle(1); wait_drain(1);
        rv_t1.delete();
        max_out[1] = 0;
        issue(1, 1'b0, 32'h0, 4'hF, 32'h0, w0, gt0);
        issue(1, 1'b0, 32'h4, 4'hF, 32'h0, w1, gt);
        issue(1, 1'b0, 32'h8, 4'hF, 32'h0, w2, gt);
        idle(1); wait_drain(1);
        checks++;
        if (w0 + w1 + w2 != 0) begin
            failures++;
            $display("FAIL b2b_gnt: got %0d stall cycles want 0", w0 + w1 + w2);
        end
        checks++;
        if (rv_t1.size() != 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d rvalids want 3", rv_t1.size());
        end else begin
            checks++;
            if ((rv_t1[0] - gt0) !== 64'd20 || (rv_t1[1] - rv_t1[0]) !== 64'd10 ||
                (rv_t1[2] - rv_t1[1]) !== 64'd10) begin
                failures++;
                $display("FAIL b2b_timing: got %0t/%0t/%0t want 20/10/10",
                         rv_t1[0] - gt0, rv_t1[1] - rv_t1[0], rv_t1[2] - rv_t1[1]);
            end
        end
        checks++;
        if (max_out[1] != 2) begin
            failures++;
            $display("FAIL b2b_outstanding: got max %0d want 2", max_out[1]);
        end
        checks++;
        if (last_rd[1] !== 32'h33333333) begin
            failures++;
            $display("FAIL b2b_last: got %h want 33333333", last_rd[1]);
        end
    endtask

    task automatic test_stall();
        int w, rvc; time gt;
        issue(0, 1'b1, 32'h20, 4'hF, 32'hA5A5A5A5, w, gt); idle(0); wait_drain(0);
        rvc = rv_count[0];
        stall[0] = 1'b1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; be[0] = 4'hF; wdata[0] = 32'h5A5A5A5A;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (gnt[0] !== 1'b0 || u_dut0.mem[8] !== 32'hA5A5A5A5) begin
                failures++;
                $display("FAIL stall_hold: got gnt=%b mem=%h want 0/a5a5a5a5", gnt[0], u_dut0.mem[8]);
            end
        end
        @(posedge clk); #1;
        stall[0] = 1'b0;
        issue(0, 1'b1, 32'h20, 4'hF, 32'h5A5A5A5A, w, gt); idle(0); wait_drain(0);
        checks++;
        if (w != 0 || rv_count[0] - rvc != 1) begin
            failures++;
            $display("FAIL stall_release: got wait=%0d rvalids=%0d want 0/1", w, rv_count[0] - rvc);
        end
        issue(0, 1'b0, 32'h20, 4'hF, 32'h0, w, gt); idle(0); wait_drain(0);
        checks++;
        if (last_rd[0] !== 32'h5A5A5A5A) begin
            failures++;
            $display("FAIL stall_data: got %h want 5a5a5a5a", last_rd[0]);
        end
    endtask

    task automatic test_out_of_range();
        int w; time gt;
        issue(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, w, gt);
        issue(0, 1'b1, 32'h1000, 4'hF, 32'hBAD0BAD0, w, gt);
        issue(0, 1'b0, 32'h1000, 4'hF, 32'h0, w, gt); idle(0); wait_drain(0);
        checks++;
        if (last_err[0] !== 1'b1 || last_rd[0] !== 32'h0) begin
            failures++;
            $display("FAIL oor_read: got err=%b rd=%h want 1/0", last_err[0], last_rd[0]);
        end
        issue(0, 1'b0, 32'h0, 4'hF, 32'h0, w, gt); idle(0); wait_drain(0);
        checks++;
        if (last_rd[0] !== 32'hCAFEF00D || last_err[0] !== 1'b0) begin
            failures++;
            $display("FAIL oor_alias: got %h err=%b want cafef00d/0", last_rd[0], last_err[0]);
        end
    endtask

    task automatic test_reset_mid();
        int w, rvc; time gt;
        issue(1, 1'b1, 32'h40, 4'hF, 32'h0BADCAFE, w, gt);
        issue(1, 1'b0, 32'h44, 4'hF, 32'h0, w, gt);
        req[1] = 1'b0;
        rst = 1'b1;
        rvc = rv_count[1];
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (rvalid[1] !== 1'b0) begin
                failures++;
                $display("FAIL reset_drop: got rvalid=1 want 0 t=%0t", $time);
            end
        end
        checks++;
        if (rv_count[1] != rvc) begin
            failures++;
            $display("FAIL reset_drop_count: got %0d want %0d", rv_count[1], rvc);
        end
        @(posedge clk); #1;
        issue(1, 1'b0, 32'h40, 4'hF, 32'h0, w, gt); idle(1); wait_drain(1);
        checks++;
        if (last_rd[1] !== 32'h0BADCAFE) begin
            failures++;
            $display("FAIL reset_persist: got %h want 0badcafe", last_rd[1]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_back_to_back();
        test_stall();
        test_out_of_range();
        test_reset_mid();
        wait_drain(0);
        wait_drain(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
